// File: rtl/id_ex_pipe_reg.sv
// Decode-to-Execute pipeline register with hazard-unit stall/flush control.
// Optional: define IDEX_BUBBLE_CNT_EN to add the saturating BubbleCnt flush counter.
module id_ex_pipe_reg #(
    parameter int W    = 32,
    parameter int RA   = 5,
    parameter int ALUC = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic [W-1:0]    RD1D,
    input  logic [W-1:0]    RD2D,
    input  logic [W-1:0]    PCD,
    input  logic [W-1:0]    PCPlus4D,
    input  logic [W-1:0]    ImmExtD,
    input  logic [RA-1:0]   Rs1D,
    input  logic [RA-1:0]   Rs2D,
    input  logic [RA-1:0]   RdD,
    input  logic            RegWriteD,
    input  logic [1:0]      ResultSrcD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            ALUSrcD,
    input  logic [ALUC-1:0] ALUControlD,
    output logic            ValidE,
    output logic [W-1:0]    RD1E,
    output logic [W-1:0]    RD2E,
    output logic [W-1:0]    PCE,
    output logic [W-1:0]    PCPlus4E,
    output logic [W-1:0]    ImmExtE,
    output logic [RA-1:0]   Rs1E,
    output logic [RA-1:0]   Rs2E,
    output logic [RA-1:0]   RdE,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
`ifdef IDEX_BUBBLE_CNT_EN
    output logic [31:0]     BubbleCnt,
`endif
    output logic [ALUC-1:0] ALUControlE
);

    typedef struct packed {
        logic            valid;
        logic [W-1:0]    rd1;
        logic [W-1:0]    rd2;
        logic [W-1:0]    pc;
        logic [W-1:0]    pc_plus4;
        logic [W-1:0]    imm_ext;
        logic [RA-1:0]   rs1;
        logic [RA-1:0]   rs2;
        logic [RA-1:0]   rd;
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic            alu_src;
        logic [ALUC-1:0] alu_control;
    } ex_fields_t;

    ex_fields_t fields_in;
    ex_fields_t fields_d;
    ex_fields_t fields_q;

    always_comb begin
        fields_in             = '0;
        fields_in.valid       = ValidD;
        fields_in.rd1         = RD1D;
        fields_in.rd2         = RD2D;
        fields_in.pc          = PCD;
        fields_in.pc_plus4    = PCPlus4D;
        fields_in.imm_ext     = ImmExtD;
        fields_in.rs1         = Rs1D;
        fields_in.rs2         = Rs2D;
        fields_in.rd          = RdD;
        fields_in.reg_write   = RegWriteD;
        fields_in.result_src  = ResultSrcD;
        fields_in.mem_write   = MemWriteD;
        fields_in.jump        = JumpD;
        fields_in.branch      = BranchD;
        fields_in.alu_src     = ALUSrcD;
        fields_in.alu_control = ALUControlD;
    end

    // Flush beats stall; an all-zero bundle is a bubble with RdE=x0, so it never forwards.
    always_comb begin
        fields_d = fields_q;
        if (FlushE) begin
            fields_d = '0;
        end else if (!StallE) begin
            fields_d = fields_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fields_q <= '0;
        end else begin
            fields_q <= fields_d;
        end
    end

    assign ValidE      = fields_q.valid;
    assign RD1E        = fields_q.rd1;
    assign RD2E        = fields_q.rd2;
    assign PCE         = fields_q.pc;
    assign PCPlus4E    = fields_q.pc_plus4;
    assign ImmExtE     = fields_q.imm_ext;
    assign Rs1E        = fields_q.rs1;
    assign Rs2E        = fields_q.rs2;
    assign RdE         = fields_q.rd;
    assign RegWriteE   = fields_q.reg_write;
    assign ResultSrcE  = fields_q.result_src;
    assign MemWriteE   = fields_q.mem_write;
    assign JumpE       = fields_q.jump;
    assign BranchE     = fields_q.branch;
    assign ALUSrcE     = fields_q.alu_src;
    assign ALUControlE = fields_q.alu_control;

`ifdef IDEX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_d;
    logic [31:0] bubble_cnt_q;

    // Counts every flush edge, saturating rather than wrapping; stalls are ignored.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (FlushE && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign BubbleCnt = bubble_cnt_q;
`endif

endmodule
